// File: rtl/uart_dev_responder.sv
// Device-side parallel UART: byte writes from the controller are sent on txd as 8N1,
// bytes received on rxd are buffered for strobe-driven reads over the shared bus.
module uart_dev_responder #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_oe,
    input  logic        rdn,
    input  logic        wrn,
    output logic        data_ready,
    output logic        tbre,
    output logic        tsre,
    input  logic        rxd,
    output logic        txd,
    input  logic        clear_err,
    output logic [2:0]  err_flags
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t        tx_state, tx_state_next;
    rx_state_t        rx_state, rx_state_next;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_next, rx_cnt, rx_cnt_next;
    logic [2:0]       tx_bit, tx_bit_next, rx_bit, rx_bit_next;
    logic [2:0]       rdn_sync, wrn_sync, rxd_sync;
    logic [7:0]       thr, tsr, rbr, rx_shift;
    logic             tx_load, tx_done, txd_next;
    logic             rx_shift_en, rx_ok, rx_ferr;
    logic [2:0]       err_next;
    logic             rd_fall, rd_rise, wr_rise, rx_fall, rxd_s2;
    logic             unused_hi;

    assign unused_hi = ^data_in[15:8];

    // Edge detection on the synchronized strobes and serial input (s2 vs s3)
    assign rd_fall = ~rdn_sync[1] &  rdn_sync[2];
    assign rd_rise =  rdn_sync[1] & ~rdn_sync[2];
    assign wr_rise =  wrn_sync[1] & ~wrn_sync[2];
    assign rx_fall = ~rxd_sync[1] &  rxd_sync[2];
    assign rxd_s2  =  rxd_sync[1];

    // State and bit counters for both serial FSMs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            tx_bit   <= '0;
            rx_bit   <= '0;
        end else begin
            tx_state <= tx_state_next;
            rx_state <= rx_state_next;
            tx_cnt   <= tx_cnt_next;
            rx_cnt   <= rx_cnt_next;
            tx_bit   <= tx_bit_next;
            rx_bit   <= rx_bit_next;
        end
    end

    // TX next state: load from THR when idle or at the end of a stop bit
    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt;
        tx_bit_next   = tx_bit;
        tx_load       = 1'b0;
        tx_done       = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tbre) begin
                    tx_state_next = TX_START;
                    tx_cnt_next   = '0;
                    tx_load       = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_next = TX_DATA;
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                end else begin
                    tx_cnt_next = tx_cnt + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_bit == 3'd7) tx_state_next = TX_STOP;
                    else                tx_bit_next   = tx_bit + 3'd1;
                end else begin
                    tx_cnt_next = tx_cnt + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_next = '0;
                    if (!tbre) begin
                        tx_state_next = TX_START;
                        tx_load       = 1'b1;
                    end else begin
                        tx_state_next = TX_IDLE;
                        tx_done       = 1'b1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    // TX output: line level for the upcoming state, registered into txd
    always_comb begin
        txd_next = 1'b1;
        case (tx_state_next)
            TX_START: txd_next = 1'b0;
            TX_DATA:  txd_next = tsr[tx_bit_next];
            default:  txd_next = 1'b1;
        endcase
    end

    // RX next state: mid-bit sampling, start-bit glitch rejection, stop check
    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt;
        rx_bit_next   = rx_bit;
        rx_shift_en   = 1'b0;
        rx_ok         = 1'b0;
        rx_ferr       = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_next = RX_START;
                    rx_cnt_next   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_next = '0;
                    rx_bit_next = '0;
                    rx_state_next = rxd_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_next = rx_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_next = '0;
                    rx_shift_en = 1'b1;
                    if (rx_bit == 3'd7) rx_state_next = RX_STOP;
                    else                rx_bit_next   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_next = rx_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_state_next = RX_IDLE;
                    rx_ok         = rxd_s2;
                    rx_ferr       = ~rxd_s2;
                end else begin
                    rx_cnt_next = rx_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    // Sticky error flags: a new event outranks clear_err
    always_comb begin
        err_next = clear_err ? 3'b000 : err_flags;
        if (rx_ferr)                           err_next[2] = 1'b1;
        if (rx_ok && data_ready && !rd_rise)   err_next[1] = 1'b1;
        if (wr_rise && !tbre)                  err_next[0] = 1'b1;
    end

    // Synchronizers, holding/shift registers, handshake flags and bus capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdn_sync   <= 3'b111;
            wrn_sync   <= 3'b111;
            rxd_sync   <= 3'b111;
            thr        <= '0;
            tsr        <= '0;
            rbr        <= '0;
            rx_shift   <= '0;
            tbre       <= 1'b1;
            tsre       <= 1'b1;
            txd        <= 1'b1;
            data_ready <= 1'b0;
            data_oe    <= 1'b0;
            data_out   <= '0;
            err_flags  <= '0;
        end else begin
            rdn_sync <= {rdn_sync[1:0], rdn};
            wrn_sync <= {wrn_sync[1:0], wrn};
            rxd_sync <= {rxd_sync[1:0], rxd};
            if (wr_rise && tbre) thr <= data_in[7:0];
            if (tx_load)         tsr <= thr;
            if (tx_load)                 tbre <= 1'b1;
            else if (wr_rise && tbre)    tbre <= 1'b0;
            if (tx_load)      tsre <= 1'b0;
            else if (tx_done) tsre <= 1'b1;
            txd <= txd_next;
            if (rx_shift_en) rx_shift <= {rxd_s2, rx_shift[7:1]};
            if (rx_ok)       rbr      <= rx_shift;
            if (rx_ok)        data_ready <= 1'b1;
            else if (rd_rise) data_ready <= 1'b0;
            if (rd_fall) begin
                data_out <= {8'h00, rbr};
                data_oe  <= 1'b1;
            end else if (rd_rise) begin
                data_oe  <= 1'b0;
            end
            err_flags <= err_next;
        end
    end

endmodule

// File: doc/uart_dev_responder.md
Name: uart_dev_responder

Overview:
- Device-side model and FPGA implementation of the parallel UART chip that the CPU memory controller talks to over rdn/wrn/data_ready/tbre/tsre and the low byte of the shared data bus.
- Serializes bytes written by the controller onto txd (8N1).
- Deserializes rxd into a one-byte receive buffer and signals data_ready.
- Drives the buffered byte onto the bus while rdn is low.
- Used as the bench-side peer for controller verification and as the soft UART on boards without the chip.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit (even, >=4)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- data_in  in  16  bus value from controller; bits [7:0] used
- data_out  out  16  {8'h00, rbr}, valid while data_oe=1
- data_oe  out  1  bus drive enable (top level builds tristate)
- rdn  in  1  read strobe, active-low, asynchronous to clk
- wrn  in  1  write strobe, active-low, asynchronous to clk
- data_ready  out  1  receive buffer holds an unread byte
- tbre  out  1  transmit holding register empty
- tsre  out  1  transmit shift register empty (line idle)
- rxd  in  1  serial input, idle high
- txd  out  1  serial output, idle high
- clear_err  in  1  synchronous clear of sticky error flags
- err_flags  out  3  {framing_err, rx_overrun, tx_overrun}, sticky

Behaviour:
- Reset (async, any state): txd=1, tbre=1, tsre=1, data_ready=0, data_oe=0, data_out=0, err_flags=0, both FSMs idle, bit counters 0.
- rdn, wrn and rxd each pass through a 2-flop synchronizer (s1, s2) plus a third register s3. Edges are detected from s2 against s3.
- Write:
  - wrn rising edge detected (s2=1, s3=0) with tbre=1: thr<=data_in[7:0] and tbre<=0 in the same cycle. tbre is low 3 clk after the wrn rising edge is first sampled.
  - If tbre=0 at detection: tx_overrun<=1; thr unchanged.
- TX FSM states: TX_IDLE, TX_START, TX_DATA, TX_STOP.
  - TX_IDLE with tbre=0: tsr<=thr, tbre<=1, tsre<=0, go TX_START.
  - Each of TX_START, TX_DATA and TX_STOP lasts exactly CLKS_PER_BIT cycles.
  - txd is 0 in TX_START, tsr[bit] LSB-first in TX_DATA (8 bits), 1 in TX_STOP.
  - End of TX_STOP with tbre=0: reload and go straight to TX_START, so frames are back-to-back with no idle gap and tsre stays 0.
  - End of TX_STOP otherwise: tsre<=1, go TX_IDLE.
  - A THR write during a frame is accepted (tbre was 1) and queues behind the current frame.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE leaves on synced falling edge of rxd.
  - RX_START waits CLKS_PER_BIT/2 cycles. If rxd is 1 at that point, treat as a glitch and return to RX_IDLE with no flag.
  - RX_DATA samples every CLKS_PER_BIT cycles, 8 bits LSB-first.
  - RX_STOP samples CLKS_PER_BIT later.
    - Stop=1: rbr<=shift, data_ready<=1. If data_ready was already 1, rx_overrun<=1 and the new byte overwrites.
    - Stop=0: framing_err<=1, byte discarded, data_ready unchanged.
  - RX_STOP always returns to RX_IDLE. RX_IDLE re-arms only after rxd has been seen high (no re-trigger on a stuck-low line).
- Read:
  - rdn falling edge detected: data_out<={8'h00,rbr}, data_oe<=1.
  - rdn rising edge detected: data_oe<=0, data_ready<=0.
  - Read with data_ready=0 still drives the stale rbr; no flag.
  - An RX completion in the same cycle as the rdn rising edge wins: data_ready=1, rx_overrun not set.
- Simultaneous rdn and wrn edges are both serviced in the same cycle (independent paths).
- clear_err=1 clears all three flags. A flag set in the same cycle takes priority over clear.
- data_out changes only on the rdn falling-edge capture; it holds through the strobe.

Test Plan:
- CLKS_PER_BIT=4: reset then pulse wrn low→high with data_in=16'h1255 -> tbre 0 three clk later, txd frame 0,1,0,1,0,1,0,1,0,1 each 4 clk, tsre=1 after stop, tbre=1 one clk after load.
- Two writes 8'hA5 then 8'h3C, second while first frame in progress -> back-to-back frames with no idle bit, tsre stays 0 until second stop ends, err_flags=0.
- Third write while tbre=0 -> tx_overrun=1, transmitted stream unchanged; clear_err pulse -> err_flags=3'b000.
- Drive rxd frame for 8'hC3 with valid stop -> data_ready=1. Then rdn low -> data_oe=1, data_out=16'h00C3. rdn high -> data_oe=0, data_ready=0.
- Two rx frames 8'h11, 8'h22 without a read -> rx_overrun=1, read returns 16'h0022. Frame with stop=0 -> framing_err=1, data_ready unchanged.
- Assert rst mid TX frame and mid RX frame -> txd=1, tbre=tsre=1, data_ready=0 immediately. A 1-clk rxd low glitch after reset produces no byte.
